// File: rtl/uart_tx_fifo.sv
// 8-N-1 UART transmitter with a small valid/ready input FIFO.
// Bit timing uses an exact fractional accumulator, so the long-run baud rate equals uartRate.
module uart_tx_fifo #(
    parameter int unsigned clockRate = 76_800_000,
    parameter int unsigned uartRate  = 12_000_000,
    parameter int unsigned fifoDepth = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       uart,
    output logic       busy
);

    function automatic int unsigned gcd_f(input int unsigned a, input int unsigned b);
        int unsigned x;
        int unsigned y;
        int unsigned t;
        x = a;
        y = b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    localparam int unsigned GCD   = gcd_f(clockRate, uartRate);
    localparam int unsigned C     = clockRate / GCD;
    localparam int unsigned U     = uartRate / GCD;
    localparam int unsigned ACC_W = $clog2(C + U);
    localparam int unsigned SUM_W = ACC_W + 1;
    localparam int unsigned PTR_W = $clog2(fifoDepth);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [7:0]         r_mem [fifoDepth];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    logic               r_uart;
    logic [7:0]         r_shift;
    logic [2:0]         r_bit_cnt;
    logic [ACC_W-1:0]   r_acc;

    logic               w_uart_next;
    logic [7:0]         w_shift_next;
    logic [2:0]         w_bit_next;
    logic [ACC_W-1:0]   w_acc_next;
    logic               w_pop;
    logic               w_push;
    logic               w_empty;
    logic [7:0]         w_head;
    logic [SUM_W-1:0]   w_sum;
    logic               w_tick;
    logic [ACC_W-1:0]   w_acc_adv;

    always_comb begin
        w_empty = (r_count == '0);
        ready   = (r_count != CNT_W'(fifoDepth));
        busy    = (r_state != S_IDLE) || !w_empty;
        w_push  = valid && ready;
        w_head  = r_mem[r_rd_ptr];
        uart    = r_uart;
    end

    // Fractional bit-rate accumulator: tick whenever the running sum crosses C.
    always_comb begin
        w_sum  = {1'b0, r_acc} + SUM_W'(U);
        w_tick = (w_sum >= SUM_W'(C));
        if (w_tick) begin
            w_acc_adv = ACC_W'(w_sum - SUM_W'(C));
        end else begin
            w_acc_adv = ACC_W'(w_sum);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_uart_next  = r_uart;
        w_shift_next = r_shift;
        w_bit_next   = r_bit_cnt;
        w_acc_next   = r_acc;
        w_pop        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_shift_next = w_head;
                    w_acc_next   = '0;
                    w_bit_next   = '0;
                    w_uart_next  = 1'b0;
                    w_state_next = S_START;
                end else begin
                    w_uart_next  = 1'b1;
                end
            end
            S_START: begin
                w_acc_next = w_acc_adv;
                if (w_tick) begin
                    w_uart_next  = r_shift[0];
                    w_state_next = S_DATA;
                end
            end
            S_DATA: begin
                w_acc_next = w_acc_adv;
                if (w_tick) begin
                    if (r_bit_cnt == 3'd7) begin
                        w_uart_next  = 1'b1;
                        w_state_next = S_STOP;
                    end else begin
                        w_shift_next = r_shift >> 1;
                        w_bit_next   = r_bit_cnt + 3'd1;
                        w_uart_next  = r_shift[1];
                    end
                end
            end
            S_STOP: begin
                // Accumulator is kept across frames so back-to-back throughput stays exact.
                w_acc_next = w_acc_adv;
                if (w_tick) begin
                    if (!w_empty) begin
                        w_pop        = 1'b1;
                        w_shift_next = w_head;
                        w_bit_next   = '0;
                        w_uart_next  = 1'b0;
                        w_state_next = S_START;
                    end else begin
                        w_uart_next  = 1'b1;
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: begin
                w_uart_next  = 1'b1;
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_uart    <= 1'b1;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_acc     <= '0;
        end else begin
            r_uart    <= w_uart_next;
            r_shift   <= w_shift_next;
            r_bit_cnt <= w_bit_next;
            r_acc     <= w_acc_next;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data;
        end
    end

    // Pointers wrap naturally; count is one bit wider to tell full from empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
8-N-1 UART transmitter. It pairs with the receive block on the same serial link and uses the same clockRate/uartRate parameterisation, so both ends of the link agree on bit timing by construction. A small input FIFO with valid/ready handshake lets upstream logic burst bytes. Bit timing comes from an exact fractional accumulator, so the long-run baud rate equals uartRate exactly for any integer ratio.

Parameters:
clockRate, 76_800_000, clk frequency in Hz.
uartRate, 12_000_000, line bit rate in Hz; must satisfy clockRate >= uartRate.
fifoDepth, 4, FIFO entries; power of two, minimum 2.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  synchronous, active-high reset.
data  input  8  byte to transmit.
valid  input  1  data is valid this cycle.
ready  output  1  FIFO can accept a byte (not full).
uart  output  1  serial line, idle high, registered.
busy  output  1  FIFO non-empty or a frame is in progress.

Behaviour:
- Reset values: uart=1, ready=1 (combinational from the FIFO count after reset), busy=0. FIFO is emptied, the FSM goes to IDLE, and the accumulator is set to 0.
- Reset mid-frame: uart=1 on the next edge and queued bytes are discarded. A truncated frame on the line is accepted behaviour.
- Handshake: a byte is written on an edge where valid && ready. ready = (count != fifoDepth). A write while full is impossible because ready=0. A simultaneous write and read while full is not allowed; ready stays 0 until the read completes.
- Rate scaling: C = clockRate/gcd, U = uartRate/gcd, with gcd computed at elaboration. The accumulator is ceil(log2(C+U)) bits wide, unsigned.
- Bit tick: each cycle in a non-IDLE state, if acc+U >= C then tick=1 and acc <= acc+U-C; otherwise acc <= acc+U.
- Bit durations are floor(C/U) or ceil(C/U) clocks. A frame is exactly 10*C/U clocks when that is an integer. The accumulator is not cleared between back-to-back frames, so long-run throughput is exactly uartRate/10 bytes/s.
- FSM states: IDLE, START, DATA, STOP.
- IDLE: if the FIFO is non-empty, pop the head into shift[7:0], set acc=0 and bitCount=0, drive uart<=0, and go to START. Otherwise uart<=1.
- START: on tick, uart<=shift[0] and go to DATA.
- DATA: on tick, if bitCount==7 then uart<=1 and go to STOP. Otherwise shift>>=1, bitCount++, and uart<=shift[1]. Data is sent LSB first.
- STOP: on tick, if the FIFO is non-empty, pop, uart<=0, and go to START, keeping acc (no idle gap). Otherwise uart<=1 and go to IDLE.
- Latency: a byte written at edge N into an empty FIFO while IDLE drives uart low from edge N+1 (the pop happens at edge N+1).
- busy = (state != IDLE) || (count != 0).
- FIFO: read and write pointers of log2(fifoDepth) bits that wrap naturally. count is log2(fifoDepth)+1 bits wide. Simultaneous push and pop leaves count unchanged. A pop from an empty FIFO never occurs.

Test Plan:
- Defaults (C=32, U=5). Write 0x55 while idle -> uart low one edge later. Line levels 0,1,0,1,0,1,0,1,0,1 with durations 7,6,7,6,6,7,6,7,6,6 clocks (total 64). busy falls one cycle after the STOP period ends.
- clockRate=8, uartRate=1. Write 0xA3 -> uart sequence 0,1,1,0,0,0,1,0,1,1, each level exactly 8 clocks.
- Defaults. Burst five bytes 0x01..0x05 with valid held high -> ready drops after the fifth accept (four entries plus the byte in flight). Frames are back-to-back, each exactly 64 clocks with no idle cycles, and decode correctly through the team's receive block.
- Assert reset 20 clocks into a frame with 3 bytes queued -> uart=1 on the next edge, busy=0, ready=1, no further frames. A new write after reset transmits normally.
- Hold valid low for 1000 cycles after reset -> uart constant 1 and busy constant 0. A single valid pulse then produces exactly one frame.
- Random bytes, random valid gaps, 10,000 bytes -> the receive-block output matches a byte-exact scoreboard with no loss or duplication.
